alu_seq_ctrl: RTL and testbench

- Multi-cycle sequencer that performs wide (4*NIBBLES-bit) arithmetic/logic operations on the existing 4-bit combinational ALU, one nibble per cycle, LSB nibble first, chaining carry between nibbles.
- Sits between a requester (valid/ready request and response channels) and the ALU, and owns the ALU's A, B, c_in and ALUOP inputs.
- Adds subtraction on top of the ALU's add by inverting B and forcing carry-in.

---
 rtl/alu_seq_pkg.sv | 45 ++++
 rtl/alu_seq_ctrl_if.sv | 37 +++
 rtl/alu_seq_nibble_mux.sv | 29 ++
 rtl/alu_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings and helpers for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned ALUOP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_AND = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_OR  = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_is_arith(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_XOR;
  endfunction

  // Illegal ops fall through to add so the ALU sees a harmless 0+0
  function automatic logic [ALUOP_W-1:0] op_to_aluop(input logic [OP_W-1:0] op);
    logic [ALUOP_W-1:0] res;
    res = ALUOP_ADD;
    case (op)
      OP_AND:  res = ALUOP_AND;
      OP_OR:   res = ALUOP_OR;
      OP_XOR:  res = ALUOP_XOR;
      default: res = ALUOP_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response channels of the ALU sequencer.
// rsp_ovf exists only when ALU_SEQ_CTRL_OVF_EN is defined.
interface alu_seq_ctrl_if #(parameter int unsigned NIBBLES = 4);
  localparam int unsigned W = 4 * NIBBLES;

  logic           req_valid;
  logic           req_ready;
  logic [2:0]     req_op;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           req_cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_r;
  logic           rsp_carry;
  logic           rsp_zero;
  logic           rsp_sign;
`ifdef ALU_SEQ_CTRL_OVF_EN
  logic           rsp_ovf;
`endif

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_carry, rsp_zero, rsp_sign
`ifdef ALU_SEQ_CTRL_OVF_EN
    , input rsp_ovf
`endif
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_carry, rsp_zero, rsp_sign
`ifdef ALU_SEQ_CTRL_OVF_EN
    , output rsp_ovf
`endif
  );
endinterface

// File: rtl/alu_seq_nibble_mux.sv
// Selects nibble k of the operands for the ALU and merges the ALU result into slot k.
module alu_seq_nibble_mux #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic [4*NIBBLES-1:0]                         a_i,
  input  logic [4*NIBBLES-1:0]                         b_i,
  input  logic [((NIBBLES > 1) ? $clog2(NIBBLES) : 1)-1:0] k_i,
  input  logic                                         en_i,
  input  logic [4*NIBBLES-1:0]                         result_i,
  input  logic [3:0]                                   alu_r_i,
  output logic [3:0]                                   alu_a_o,
  output logic [3:0]                                   alu_b_o,
  output logic [4*NIBBLES-1:0]                         result_o
);
  localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  always_comb begin
    alu_a_o  = 4'h0;
    alu_b_o  = 4'h0;
    result_o = result_i;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (en_i && (KW'(n) == k_i)) begin
        alu_a_o             = a_i[4*n +: 4];
        alu_b_o             = b_i[4*n +: 4];
        result_o[4*n +: 4]  = alu_r_i;
      end
    end
  end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences a 4*NIBBLES-bit op over an external 4-bit ALU, one nibble per cycle, LSB first.
// Optional signed-overflow output enabled by ALU_SEQ_CTRL_OVF_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  alu_seq_ctrl_if.slave       bus,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  output logic                alu_cin,
  output logic [ALUOP_W-1:0]  alu_op,
  input  logic [3:0]          alu_r,
  input  logic                alu_cout
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e          state_q;
  logic [OP_W-1:0] op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic [KW-1:0]   k_q;
  logic            carry_q;
  logic            rsp_valid_q;
  logic            zero_q;
`ifdef ALU_SEQ_CTRL_OVF_EN
  logic            ovf_q;
`endif

  logic         exec;
  logic         last_nib;
  logic [3:0]   alu_r_gated;
  logic [W-1:0] result_nxt;
  logic         carry_nxt;

  assign exec        = (state_q == ST_EXEC);
  assign last_nib    = (k_q == KW'(NIBBLES - 1));
  assign alu_r_gated = op_is_legal(op_q) ? alu_r : 4'h0;
  assign carry_nxt   = op_is_arith(op_q) & alu_cout;
  assign alu_cin     = exec & carry_q;
  assign alu_op      = exec ? op_to_aluop(op_q) : ALUOP_ADD;

  alu_seq_nibble_mux #(.NIBBLES(NIBBLES)) u_nibble_mux (
    .a_i      (a_q),
    .b_i      (b_q),
    .k_i      (k_q),
    .en_i     (exec),
    .result_i (result_q),
    .alu_r_i  (alu_r_gated),
    .alu_a_o  (alu_a),
    .alu_b_o  (alu_b),
    .result_o (result_nxt)
  );

  // Ready is suppressed combinationally while reset is asserted
  assign bus.req_ready = (state_q == ST_IDLE) && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_r     = result_q;
  assign bus.rsp_carry = carry_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_sign  = result_q[W-1];
`ifdef ALU_SEQ_CTRL_OVF_EN
  assign bus.rsp_ovf   = ovf_q;
`endif

  // Sequencer FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      k_q         <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      zero_q      <= 1'b0;
`ifdef ALU_SEQ_CTRL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            // Illegal ops latch zero operands so the ALU computes 0+0
            op_q    <= bus.req_op;
            a_q     <= op_is_legal(bus.req_op) ? bus.req_a : '0;
            b_q     <= !op_is_legal(bus.req_op) ? '0 :
                       (bus.req_op == OP_SUB) ? ~bus.req_b : bus.req_b;
            k_q     <= '0;
            carry_q <= (bus.req_op == OP_SUB) ? 1'b1 :
                       (bus.req_op == OP_ADD) ? bus.req_cin : 1'b0;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q <= result_nxt;
          carry_q  <= carry_nxt;
          k_q      <= k_q + KW'(1);
          if (last_nib) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            zero_q      <= (result_nxt == '0);
`ifdef ALU_SEQ_CTRL_OVF_EN
            ovf_q       <= op_is_arith(op_q) && (a_q[W-1] == b_q[W-1]) &&
                           (result_nxt[W-1] != a_q[W-1]);
`endif
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed, table-driven bench for alu_seq_ctrl with a behavioural 4-bit ALU.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int unsigned NIB = 4;
  localparam int unsigned NV  = 13;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] alu_a, alu_b, alu_r;
  logic       alu_cin, alu_cout;
  logic [1:0] alu_op;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.NIBBLES(NIB)) bus_if ();

  alu_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if.slave),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_op   (alu_op),
    .alu_r    (alu_r),
    .alu_cout (alu_cout)
  );

  // Reference 4-bit ALU
  always_comb begin
    alu_r    = 4'h0;
    alu_cout = 1'b0;
    case (alu_op)
      2'b00:   {alu_cout, alu_r} = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
      2'b01:   alu_r = alu_a & alu_b;
      2'b10:   alu_r = alu_a | alu_b;
      default: alu_r = alu_a ^ alu_b;
    endcase
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] r;
    logic        c;
    logic        z;
    logic        s;
    logic        o;
    logic [1:0]  aop;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_rsp(input string nm, output int lat);
    lat = 0;
    while (!bus_if.rsp_valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (!bus_if.rsp_valid) begin
      n_cmp++; n_err++;
      $display("FAIL %s: rsp_valid timeout got 0 expected 1", nm);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output logic [15:0] r, output logic c, output logic z,
                        output logic s, output logic o, output int lat, output logic [3:0] fa,
                        output logic [3:0] fb, output logic fc, output logic [1:0] fop);
    int g;
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.req_a     = a;
    bus_if.req_b     = b;
    bus_if.req_cin   = cin;
    g = 0;
    while (!bus_if.req_ready && g < 50) begin
      @(negedge clk); g++;
    end
    if (!bus_if.req_ready) begin
      n_cmp++; n_err++;
      $display("FAIL req_ready timeout got 0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    fa = alu_a; fb = alu_b; fc = alu_cin; fop = alu_op;
    wait_rsp("run_op", lat);
    r = bus_if.rsp_r; c = bus_if.rsp_carry; z = bus_if.rsp_zero; s = bus_if.rsp_sign;
`ifdef ALU_SEQ_CTRL_OVF_EN
    o = bus_if.rsp_ovf;
`else
    o = 1'b0;
`endif
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic        c, z, s, o, fc, legal;
    logic [3:0]  fa, fb, efa, efb;
    logic [1:0]  fop;
    logic        efc, seen;
    int          lat;

    vecs[0]  = '{OP_ADD, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[1]  = '{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[2]  = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
    vecs[3]  = '{OP_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[4]  = '{OP_SUB, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[5]  = '{OP_AND, 16'hF0A5, 16'h0FF0, 1'b1, 16'h00A0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[6]  = '{OP_OR,  16'hF0A5, 16'h0FF0, 1'b1, 16'hFFF5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
    vecs[7]  = '{OP_XOR, 16'hF0A5, 16'h0FF0, 1'b0, 16'hFF55, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11};
    vecs[8]  = '{3'b111, 16'hF0A5, 16'h0FF0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[9]  = '{OP_ADD, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[10] = '{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[11] = '{OP_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[12] = '{3'b101, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};

    reset = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = 3'd0;
    bus_if.req_a     = 16'h0;
    bus_if.req_b     = 16'h0;
    bus_if.req_cin   = 1'b0;
    bus_if.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.req_ready", 32'(bus_if.req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst.rsp_r", 32'(bus_if.rsp_r), 32'd0);
    chk("rst.flags", 32'({bus_if.rsp_carry, bus_if.rsp_zero, bus_if.rsp_sign}), 32'd0);
    chk("rst.alu", 32'({alu_a, alu_b, alu_cin, alu_op}), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.ready_after", 32'(bus_if.req_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, r, c, z, s, o, lat, fa, fb, fc, fop);
      legal = (vecs[i].op <= 3'd4);
      efa   = legal ? vecs[i].a[3:0] : 4'h0;
      efb   = !legal ? 4'h0 : (vecs[i].op == OP_SUB) ? ~vecs[i].b[3:0] : vecs[i].b[3:0];
      efc   = (vecs[i].op == OP_SUB) ? 1'b1 : (vecs[i].op == OP_ADD) ? vecs[i].cin : 1'b0;
      chk($sformatf("v%0d.rsp_r", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("v%0d.carry", i), 32'(c), 32'(vecs[i].c));
      chk($sformatf("v%0d.zero", i), 32'(z), 32'(vecs[i].z));
      chk($sformatf("v%0d.sign", i), 32'(s), 32'(vecs[i].s));
      chk($sformatf("v%0d.latency", i), 32'(lat), 32'(NIB));
      chk($sformatf("v%0d.alu_op", i), 32'(fop), 32'(vecs[i].aop));
      chk($sformatf("v%0d.alu_a0", i), 32'(fa), 32'(efa));
      chk($sformatf("v%0d.alu_b0", i), 32'(fb), 32'(efb));
      chk($sformatf("v%0d.alu_cin0", i), 32'(fc), 32'(efc));
`ifdef ALU_SEQ_CTRL_OVF_EN
      chk($sformatf("v%0d.ovf", i), 32'(o), 32'(vecs[i].o));
`endif
    end
    @(negedge clk);
    chk("idle.alu", 32'({alu_a, alu_b, alu_cin, alu_op}), 32'd0);

    // Backpressure with a second request held
    bus_if.rsp_ready = 1'b0;
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = OP_ADD;
    bus_if.req_a     = 16'h1234;
    bus_if.req_b     = 16'h0FFF;
    bus_if.req_cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus_if.req_a = 16'h0001;
    bus_if.req_b = 16'h0002;
    wait_rsp("bp.first", lat);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("bp%0d.rsp_valid", j), 32'(bus_if.rsp_valid), 32'd1);
      chk($sformatf("bp%0d.rsp_r", j), 32'(bus_if.rsp_r), 32'h2233);
      chk($sformatf("bp%0d.carry", j), 32'(bus_if.rsp_carry), 32'd0);
      chk($sformatf("bp%0d.req_ready", j), 32'(bus_if.req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus_if.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.post_hs_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("bp.post_hs_ready", 32'(bus_if.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    wait_rsp("bp.second", lat);
    chk("bp.second_r", 32'(bus_if.rsp_r), 32'h0003);
    chk("bp.second_lat", 32'(lat), 32'(NIB));
    @(posedge clk);

    // Reset asserted in the second EXEC cycle
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = OP_ADD;
    bus_if.req_a     = 16'hFFFF;
    bus_if.req_b     = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort.rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("abort.rsp_r", 32'(bus_if.rsp_r), 32'd0);
    chk("abort.req_ready", 32'(bus_if.req_ready), 32'd0);
    chk("abort.alu", 32'({alu_a, alu_b, alu_cin, alu_op}), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort.ready_after", 32'(bus_if.req_ready), 32'd1);
    seen = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      seen = seen | bus_if.rsp_valid;
    end
    chk("abort.no_rsp", 32'(seen), 32'd0);
    run_op(OP_ADD, 16'h0001, 16'h0001, 1'b0, r, c, z, s, o, lat, fa, fb, fc, fop);
    chk("abort.next_r", 32'(r), 32'h0002);
    chk("abort.next_carry", 32'(c), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
